// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage responder: FSM states, operation codes
// and the wait-counter width.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  localparam int CTR_W = 8;

  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Saturating 8-bit wait counter for the MEM stage; expired_o flags the cycle
// whose increment brings the count to TIMEOUT.
module mem_wait_ctr
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CTR_W-1:0] TIMEOUT_CNT = CTR_W'(TIMEOUT);

  logic [CTR_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CTR_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CTR_W-1){1'b0}}, 1'b1};
    end
  end

  // Looking at cnt_d lets the FSM abort on the edge that completes the
  // TIMEOUT-th wait cycle rather than one cycle later.
  assign expired_o = (cnt_d == TIMEOUT_CNT);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage_responder.sv
// MEM-stage responder: turns an enmem pulse into a req/ack data-memory access.
// Optional access timeout is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage_responder
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enmem,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] rdata_out,
  output logic              done,
  output logic              stall,
  output logic              err_timeout,
  output logic              err_overrun
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_stage_responder: TIMEOUT must be in 1..255");
  end

  state_t            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;
  logic              err_timeout_q;
  logic              err_overrun_q;
  logic              start_access;
  logic              timeout_hit;

  assign start_access = (state_q == S_IDLE) && enmem && is_mem_op(op);
  assign stall        = start_access || (state_q == S_ACCESS);

`ifdef MEM_STAGE_TIMEOUT_EN
  mem_wait_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != S_ACCESS),
    .en_i     (state_q == S_ACCESS),
    .expired_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: the data-path registers are reset too, because rdata_out and the
  // request fields must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (enmem) begin
            if (is_mem_op(op)) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= (op == OP_STORE);
              mem_addr_q  <= addr;
              mem_wdata_q <= wdata;
              state_q     <= S_ACCESS;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_ACCESS: begin
          err_overrun_q <= enmem;
          // An ack that lands on the expiry cycle still completes normally.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) rdata_q <= mem_rdata;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            mem_req_q     <= 1'b0;
            err_timeout_q <= 1'b1;
            done_q        <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          err_overrun_q <= enmem;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rdata_out   = rdata_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Directed self-checking bench for mem_stage_responder (default parameters).
module tb_mem_stage_responder;

  logic        clk;
  logic        rst_n;
  logic        enmem;
  logic [1:0]  op;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] rdata_out;
  logic        done;
  logic        stall;
  logic        err_timeout;
  logic        err_overrun;

  int passed;
  int total;

  mem_stage_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enmem      (enmem),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .rdata_out  (rdata_out),
    .done       (done),
    .stall      (stall),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enmem = 1'b0; op = 2'b00; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, rdata_out, done, stall, err_timeout, err_overrun} !== 45'd0)
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wd=%h rd=%h done=%b stall=%b to=%b ov=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, rdata_out, done, stall, err_timeout, err_overrun);
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_immediate();
    enmem = 1'b1; op = 2'b01; addr = 8'h10;
    #1;
    total++; if (stall !== 1'b1) $display("FAIL load_stall_issue got=%b want=1", stall); else passed++;
    tick();  // cycle N+1
    enmem = 1'b0; op = 2'b00; addr = 8'h00;
    total++;
    if ({mem_req, mem_we, mem_addr, done} !== {1'b1, 1'b0, 8'h10, 1'b0})
      $display("FAIL load_req got req=%b we=%b addr=%h done=%b want 1 0 10 0", mem_req, mem_we, mem_addr, done);
    else passed++;
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();  // cycle N+2
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    #1;
    total++;
    if ({mem_req, done, rdata_out, stall} !== {1'b0, 1'b1, 16'hBEEF, 1'b0})
      $display("FAIL load_done got req=%b done=%b rd=%h stall=%b want 0 1 beef 0", mem_req, done, rdata_out, stall);
    else passed++;
    tick();  // cycle N+3
    total++; if (done !== 1'b0) $display("FAIL load_done_pulse got=%b want=0", done); else passed++;
  endtask

  task automatic test_store_wait();
    enmem = 1'b1; op = 2'b10; addr = 8'h22; wdata = 16'h1234;
    tick();  // cycle N+1
    enmem = 1'b0; op = 2'b00; addr = 8'h00; wdata = 16'h0000;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) mem_ack = 1'b1;
      #1;
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, stall, done} !== {1'b1, 1'b1, 8'h22, 16'h1234, 1'b1, 1'b0})
        $display("FAIL store_hold cycle N+%0d got req=%b we=%b addr=%h wd=%h stall=%b done=%b want 1 1 22 1234 1 0",
                 k, mem_req, mem_we, mem_addr, mem_wdata, stall, done);
      else passed++;
      tick();
    end
    mem_ack = 1'b0;  // cycle N+5
    total++;
    if ({mem_req, done, rdata_out} !== {1'b0, 1'b1, 16'hBEEF})
      $display("FAIL store_done got req=%b done=%b rd=%h want 0 1 beef", mem_req, done, rdata_out);
    else passed++;
    tick();
  endtask

  task automatic test_noop();
    logic [1:0] ops [2];
    ops[0] = 2'b00;
    ops[1] = 2'b11;
    // Ack strobes outside ACCESS must be ignored.
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      enmem = 1'b1; op = ops[i]; addr = 8'h99;
      #1;
      total++; if (stall !== 1'b0) $display("FAIL noop_stall op=%b got=%b want=0", ops[i], stall); else passed++;
      tick();
      enmem = 1'b0; op = 2'b00;
      total++;
      if ({done, mem_req} !== 2'b10) $display("FAIL noop_done op=%b got done=%b req=%b want 1 0", ops[i], done, mem_req);
      else passed++;
      tick();
      total++;
      if ({done, mem_req, rdata_out} !== {2'b00, 16'hBEEF})
        $display("FAIL noop_after op=%b got done=%b req=%b rd=%h want 0 0 beef", ops[i], done, mem_req, rdata_out);
      else passed++;
    end
    mem_ack = 1'b0; mem_rdata = 16'h0000;
  endtask

  task automatic test_overrun();
    enmem = 1'b1; op = 2'b01; addr = 8'h33; wdata = 16'h0000;
    tick();  // cycle N+1: ACCESS, second enmem arrives
    op = 2'b10; addr = 8'h44; wdata = 16'hFFFF;
    total++; if (err_overrun !== 1'b0) $display("FAIL overrun_early got=%b want=0", err_overrun); else passed++;
    tick();  // cycle N+2
    enmem = 1'b0; op = 2'b00; addr = 8'h00; wdata = 16'h0000;
    total++;
    if ({err_overrun, mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b0, 8'h33, 16'h0000})
      $display("FAIL overrun_pulse got ov=%b req=%b we=%b addr=%h wd=%h want 1 1 0 33 0000",
               err_overrun, mem_req, mem_we, mem_addr, mem_wdata);
    else passed++;
    mem_ack = 1'b1; mem_rdata = 16'h0A0A;
    tick();  // cycle N+3: DONE, enmem here is also an overrun
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    enmem = 1'b1; op = 2'b00;
    total++;
    if ({err_overrun, done, rdata_out} !== {1'b0, 1'b1, 16'h0A0A})
      $display("FAIL overrun_complete got ov=%b done=%b rd=%h want 0 1 0a0a", err_overrun, done, rdata_out);
    else passed++;
    tick();  // cycle N+4
    enmem = 1'b0;
    total++;
    if ({err_overrun, done} !== 2'b10)
      $display("FAIL overrun_in_done got ov=%b done=%b want 1 0", err_overrun, done);
    else passed++;
    tick();
  endtask

  task automatic test_timeout();
    enmem = 1'b1; op = 2'b01; addr = 8'h55;
    tick();  // cycle N+1
    enmem = 1'b0; op = 2'b00; addr = 8'h00;
`ifdef MEM_STAGE_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      total++;
      if ({mem_req, err_timeout, done} !== 3'b100)
        $display("FAIL timeout_wait cycle N+%0d got req=%b to=%b done=%b want 1 0 0", k, mem_req, err_timeout, done);
      else passed++;
      tick();
    end
    total++;  // cycle N+16
    if ({err_timeout, done, mem_req, rdata_out} !== {3'b110, 16'h0A0A})
      $display("FAIL timeout_fire got to=%b done=%b req=%b rd=%h want 1 1 0 0a0a", err_timeout, done, mem_req, rdata_out);
    else passed++;
    tick();
    total++;
    if ({err_timeout, done} !== 2'b00) $display("FAIL timeout_pulse got to=%b done=%b want 0 0", err_timeout, done);
    else passed++;
`else
    for (int k = 1; k <= 20; k++) begin
      total++;
      if ({mem_req, err_timeout, done} !== 3'b100)
        $display("FAIL notimeout_wait cycle N+%0d got req=%b to=%b done=%b want 1 0 0", k, mem_req, err_timeout, done);
      else passed++;
      if (k == 20) begin mem_ack = 1'b1; mem_rdata = 16'h0A0A; end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    total++;
    if ({err_timeout, done, mem_req, rdata_out} !== {3'b010, 16'h0A0A})
      $display("FAIL notimeout_done got to=%b done=%b req=%b rd=%h want 0 1 0 0a0a", err_timeout, done, mem_req, rdata_out);
    else passed++;
    tick();
`endif
  endtask

  task automatic test_reset_mid_access();
    enmem = 1'b1; op = 2'b01; addr = 8'h66;
    tick();
    enmem = 1'b0; op = 2'b00; addr = 8'h00;
    total++; if (mem_req !== 1'b1) $display("FAIL rst_mid_pre got req=%b want=1", mem_req); else passed++;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, rdata_out, done, stall, err_timeout, err_overrun} !== 45'd0)
      $display("FAIL rst_mid_outputs got req=%b we=%b addr=%h wd=%h rd=%h done=%b stall=%b to=%b ov=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, rdata_out, done, stall, err_timeout, err_overrun);
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    tick();
    total++;
    if ({done, err_timeout, err_overrun, mem_req} !== 4'b0000)
      $display("FAIL rst_mid_quiet got done=%b to=%b ov=%b req=%b want 0 0 0 0", done, err_timeout, err_overrun, mem_req);
    else passed++;
    enmem = 1'b1; op = 2'b01; addr = 8'h77;
    tick();
    enmem = 1'b0; op = 2'b00; addr = 8'h00;
    total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h77})
      $display("FAIL rst_mid_reload_req got req=%b we=%b addr=%h want 1 0 77", mem_req, mem_we, mem_addr);
    else passed++;
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    total++;
    if ({done, rdata_out} !== {1'b1, 16'h5A5A})
      $display("FAIL rst_mid_reload_done got done=%b rd=%h want 1 5a5a", done, rdata_out);
    else passed++;
    tick();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_load_immediate();
    test_store_wait();
    test_noop();
    test_overrun();
    test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_stage_responder.md
# mem_stage_responder

Responder side of the stage-enable interface for the multi-cycle RISC core. The control unit pulses `enmem` for one cycle in its MEM state. This block accepts that pulse and runs a load or store against data memory over a req/ack handshake. It returns load data with a `done` pulse and raises `stall` while the access is outstanding, so a stall-aware sequencer can hold its state.

## Interface
Parameters:
- `ADDR_W`, default 8: data memory address width.
- `DATA_W`, default 16: data word width.
- `TIMEOUT`, default 15: maximum wait cycles for `mem_ack`. Legal range 1..255.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enmem` in 1: stage enable from the control unit. One-cycle pulse.
- `op` in 2: operation. 00 none, 01 load, 10 store, 11 reserved.
- `addr` in ADDR_W: effective address from the ALU stage.
- `wdata` in DATA_W: store data.
- `mem_req` out 1: memory request. Held until acked.
- `mem_we` out 1: 1 means write, 0 means read. Valid while `mem_req` is high.
- `mem_addr` out ADDR_W: registered request address.
- `mem_wdata` out DATA_W: registered store data.
- `mem_rdata` in DATA_W: read data. Valid in the cycle `mem_ack` is high.
- `mem_ack` in 1: memory completion.
- `rdata_out` out DATA_W: last loaded word. Held until the next load completes.
- `done` out 1: one-cycle completion pulse.
- `stall` out 1: stage not complete.
- `err_timeout` out 1: one-cycle pulse when an access is aborted by timeout.
- `err_overrun` out 1: one-cycle pulse when `enmem` arrives while the block is busy.

## Operation
- States are IDLE, ACCESS and DONE.
- IDLE + `enmem`:
  - op 01 or 10: latch `addr`, `wdata` and `mem_we` (1 for op 10), set `mem_req`, go to ACCESS.
  - op 00 or 11: go to DONE with no memory access.
- IDLE without `enmem`: stay in IDLE.
- ACCESS + `mem_ack`:
  - Clear `mem_req`.
  - For a load, capture `mem_rdata` into `rdata_out`.
  - Go to DONE.
- ACCESS without `mem_ack`: stay in ACCESS. Increment the wait counter.
- DONE: assert `done` for this single cycle, then go to IDLE.
- `mem_ack` outside ACCESS is ignored.
- `enmem` in ACCESS or DONE is ignored; pulse `err_overrun` the next cycle. Latched request fields are unchanged.
- Outputs `mem_addr`, `mem_wdata` and `mem_we` are stable for the whole time `mem_req` is high.
- Reset values: state IDLE; every output 0, including `rdata_out`; wait counter 0.
- Reset asserted mid-ACCESS: `mem_req` drops immediately (asynchronous). No `done` and no error pulse follows.

## Timing
- Cycle numbering: `enmem` is sampled high at edge N.
- `mem_req` is high from cycle N+1.
- Earliest `mem_ack` is in cycle N+1. In that case `done` and the new `rdata_out` appear in cycle N+2.
- General case: an ack in cycle N+k gives `done` in cycle N+k+1.
- A no-op (op 00 or 11) gives `done` in cycle N+1.
- `stall` is combinational: (IDLE and `enmem` and op in {01,10}) or state == ACCESS. It is low in DONE.
- The wait counter is cleared on entry to ACCESS and saturates at its width.

## Configuration
- Macro `MEM_STAGE_TIMEOUT_EN`, defined:
  - If `mem_ack` has not arrived after TIMEOUT cycles in ACCESS, drop `mem_req`, pulse `err_timeout` and go to DONE.
  - `rdata_out` is not updated on a timeout.
  - Timeout case: `enmem` at edge N, no ack. `mem_req` is high for cycles N+1..N+TIMEOUT. `err_timeout` and `done` are both high in cycle N+TIMEOUT+1.
- Macro undefined:
  - No counter logic.
  - The block waits in ACCESS indefinitely.
  - `err_timeout` is tied to 0.

## Structure
- Shared package `mem_stage_pkg` holds:
  - state encoding constants S_IDLE=2'd0, S_ACCESS=2'd1, S_DONE=2'd2;
  - op encodings OP_NONE, OP_LOAD, OP_STORE, OP_RSVD.
- One sub-module, `mem_wait_ctr`: 8-bit saturating counter with clear and enable inputs and an `expired` output (count == TIMEOUT). Instantiated only under `MEM_STAGE_TIMEOUT_EN`.

## Test plan
- Load with immediate ack: `enmem`, op 01, addr 8'h10; `mem_ack` in N+1 with rdata 16'hBEEF. Expect `mem_req` high only in N+1, `mem_we`=0, `done` and `rdata_out`=16'hBEEF in N+2.
- Store with 3 wait cycles: op 10, addr 8'h22, wdata 16'h1234; ack in N+4. Expect `mem_req`/`mem_we`=1 and stable addr/data in N+1..N+4, `stall` high, `done` in N+5, `rdata_out` unchanged.
- No-op and reserved op: op 00, then op 11. Expect `done` in N+1 each time, `mem_req` never high.
- Overrun: second `enmem` while in ACCESS. Expect `err_overrun` pulse one cycle later and the original request completes unchanged.
- Timeout (macro defined, TIMEOUT=15): load, never ack. Expect `mem_req` in N+1..N+15, `err_timeout` and `done` in N+16, `rdata_out` held.
- Reset mid-access: assert `rst_n`=0 during ACCESS. Expect `mem_req`=0 immediately, all outputs 0; after release, a new load completes normally.
